// File: rtl/spi_frame_receiver_if.sv
// SPI pins and game-side outputs of spi_frame_receiver.
// The master modport is the MCU/consumer view; the slave modport is the receiver.
interface spi_frame_receiver_if #(
  parameter int ERR_CNT_BITS = 8
);
  logic                    sck;
  logic                    sdi;
  logic                    ce;
  logic                    sdo;
  logic [3:0]              GAME_frame_select;
  logic                    GAME_new_frame_ready;
  logic                    packet_error;
  logic [ERR_CNT_BITS-1:0] error_count;

  modport master (
    output sck, sdi, ce,
    input  sdo, GAME_frame_select, GAME_new_frame_ready, packet_error, error_count
  );

  modport slave (
    input  sck, sdi, ce,
    output sdo, GAME_frame_select, GAME_new_frame_ready, packet_error, error_count
  );
endinterface

// File: rtl/spi_frame_receiver.sv
// Oversampled SPI command receiver: validates header(+checksum), pulses frame ready/error, returns status on sdo.
// Define SPI_FRAME_CHECKSUM_EN for 2-byte packets {header, ~header}; otherwise packets are header only.
module spi_frame_receiver #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [3:0] SYNC_NIBBLE  = 4'hA,
  parameter int         ERR_CNT_BITS = 8
) (
  input  logic                 HSOSC_clk,
  input  logic                 reset,
  spi_frame_receiver_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RECEIVE, CHECK} state_t;

`ifdef SPI_FRAME_CHECKSUM_EN
  localparam logic [1:0] EXP_BYTES = 2'd2;
`else
  localparam logic [1:0] EXP_BYTES = 2'd1;
`endif

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0]  sck_sync, sdi_sync, ce_sync, fill;
  logic                    sck_s, sdi_s, ce_s, sck_d, ce_d, armed;
  logic                    sck_rise, sck_fall, ce_rise, ce_fall;
  logic [2:0]              bit_cnt;
  logic [1:0]              byte_cnt;
  logic [6:0]              rx_shift;
  logic [7:0]              rx_next, header, status_sr;
`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0]              checksum;
`endif
  logic [3:0]              frame_select;
  logic                    frame_ready, pkt_err, last_ok, pkt_ok;
  logic [ERR_CNT_BITS-1:0] err_cnt;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign ce_s     = ce_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  // A transfer may only start once ce has been seen low after the chain refilled from reset.
  assign ce_rise  = ce_s & ~ce_d & armed;
  assign ce_fall  = ~ce_s & ce_d;
  assign rx_next  = {rx_shift, sdi_s};

  always_ff @(posedge HSOSC_clk or posedge reset) begin
    if (reset) begin
      sck_sync <= '0;
      sdi_sync <= '0;
      ce_sync  <= '0;
      fill     <= '0;
      sck_d    <= 1'b0;
      ce_d     <= 1'b0;
      armed    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
      ce_sync  <= {ce_sync[SYNC_STAGES-2:0], bus.ce};
      fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
      sck_d    <= sck_s;
      ce_d     <= ce_s;
      if (fill[SYNC_STAGES-1] && !ce_s)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge HSOSC_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    bus.sdo  = 1'b0;
    case (state)
      IDLE:    if (ce_rise) state_nx = RECEIVE;
      RECEIVE: begin
        bus.sdo = status_sr[7];
        if (ce_fall) state_nx = CHECK;
      end
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pkt_ok = (bit_cnt == 3'd0) && (byte_cnt == EXP_BYTES) && (header[7:4] == SYNC_NIBBLE);
`ifdef SPI_FRAME_CHECKSUM_EN
    pkt_ok = pkt_ok && (checksum == ~header);
`endif
  end

  always_ff @(posedge HSOSC_clk or posedge reset) begin
    if (reset) begin
      bit_cnt      <= 3'd0;
      byte_cnt     <= 2'd0;
      rx_shift     <= 7'd0;
      header       <= 8'd0;
`ifdef SPI_FRAME_CHECKSUM_EN
      checksum     <= 8'd0;
`endif
      status_sr    <= 8'd0;
      frame_select <= 4'd0;
      frame_ready  <= 1'b0;
      pkt_err      <= 1'b0;
      err_cnt      <= '0;
      last_ok      <= 1'b0;
    end else begin
      frame_ready <= 1'b0;
      pkt_err     <= 1'b0;
      case (state)
        IDLE: if (ce_rise) begin
          bit_cnt   <= 3'd0;
          byte_cnt  <= 2'd0;
          status_sr <= {last_ok, &err_cnt, 2'b00, frame_select};
        end
        RECEIVE: begin
          if (sck_rise) begin
            rx_shift <= rx_next[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt == 2'd0) header <= rx_next;
`ifdef SPI_FRAME_CHECKSUM_EN
              if (byte_cnt == 2'd1) checksum <= rx_next;
`endif
              // byte_cnt == 3 marks an overflowed (too long) packet
              if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
            end
          end
          if (sck_fall)
            status_sr <= {status_sr[6:0], 1'b0};
        end
        CHECK: begin
          if (pkt_ok) begin
            frame_select <= header[3:0];
            frame_ready  <= 1'b1;
            last_ok      <= 1'b1;
          end else begin
            pkt_err <= 1'b1;
            last_ok <= 1'b0;
            if (!(&err_cnt))
              err_cnt <= err_cnt + {{(ERR_CNT_BITS-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.GAME_frame_select    = frame_select;
  assign bus.GAME_new_frame_ready = frame_ready;
  assign bus.packet_error         = pkt_err;
  assign bus.error_count          = err_cnt;

endmodule
